mix_columns_sequencer: RTL and testbench

Sequences one shared single-column MixColumns datapath (one `mixColumns` instance) over all four columns of a 128-bit AES state. Processes one column per cycle and returns the full mixed state over a valid/ready handshake. Sits between ShiftRows and AddRoundKey in the iterative round engine. A per-block bypass supports the final AES round, which skips MixColumns.

---
 rtl/mix_columns_sequencer.sv | 156 +++++++++++++++
 tb/tb_mix_columns_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_sequencer.sv
// ============================================================================
// Module   : mix_columns_sequencer (with mixColumns single-column datapath)
// Brief    : Runs one shared MixColumns column unit over the four AES columns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mixColumns (
  input  logic [7:0] inputColumn0,
  input  logic [7:0] inputColumn1,
  input  logic [7:0] inputColumn2,
  input  logic [7:0] inputColumn3,
  output logic [7:0] outputColumn0,
  output logic [7:0] outputColumn1,
  output logic [7:0] outputColumn2,
  output logic [7:0] outputColumn3
);

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_d0, w_d1, w_d2, w_d3;

  assign w_d0 = xtime(inputColumn0);
  assign w_d1 = xtime(inputColumn1);
  assign w_d2 = xtime(inputColumn2);
  assign w_d3 = xtime(inputColumn3);

  assign outputColumn0 = w_d0 ^ (w_d1 ^ inputColumn1) ^ inputColumn2 ^ inputColumn3;
  assign outputColumn1 = inputColumn0 ^ w_d1 ^ (w_d2 ^ inputColumn2) ^ inputColumn3;
  assign outputColumn2 = inputColumn0 ^ inputColumn1 ^ w_d2 ^ (w_d3 ^ inputColumn3);
  assign outputColumn3 = (w_d0 ^ inputColumn0) ^ inputColumn1 ^ inputColumn2 ^ w_d3;

endmodule

module mix_columns_sequencer #(
  parameter int NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   col_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_LAST_COL = 2'(NUM_COLS - 1);

  state_t       r_state;
  logic [127:0] r_work;
  logic         r_bypass;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  // col_idx doubles as the column counter; it is held at 0 outside BUSY.
  always_comb begin
    w_col_in = r_work[127:96];
    case (col_idx)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
      default: w_col_in = r_work[127:96];
    endcase
  end

  mixColumns u_mix (
    .inputColumn0  (w_col_in[31:24]),
    .inputColumn1  (w_col_in[23:16]),
    .inputColumn2  (w_col_in[15:8]),
    .inputColumn3  (w_col_in[7:0]),
    .outputColumn0 (w_col_out[31:24]),
    .outputColumn1 (w_col_out[23:16]),
    .outputColumn2 (w_col_out[15:8]),
    .outputColumn3 (w_col_out[7:0])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_work    <= 128'h0;
      r_bypass  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_state <= 128'h0;
      busy      <= 1'b0;
      col_idx   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work   <= in_state;
            r_bypass <= in_bypass;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            col_idx  <= 2'd0;
            if (in_bypass) begin
              out_state <= in_state;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          case (col_idx)
            2'd0: out_state[127:96] <= w_col_out;
            2'd1: out_state[95:64]  <= w_col_out;
            2'd2: out_state[63:32]  <= w_col_out;
            2'd3: out_state[31:0]   <= w_col_out;
            default: out_state[127:96] <= w_col_out;
          endcase
          if (col_idx == C_LAST_COL) begin
            col_idx   <= 2'd0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            col_idx   <= col_idx + 2'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          col_idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_sequencer.sv
// ============================================================================
// Module   : tb_mix_columns_sequencer
// Brief    : Directed-vector bench with a queue scoreboard for mix_columns_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mix_columns_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   col_idx;

  localparam logic [127:0] C_V1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] C_V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] C_V2_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] C_V2_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  mix_columns_sequencer #(.NUM_COLS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .col_idx   (col_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", out_state);
      end else begin
        check("scoreboard_out_state", out_state, exp_q.pop_front());
      end
    end
  end

  // Offer a block and return #1 after its accepting edge.
  task automatic send(input logic [127:0] st, input logic byp,
                      input logic [127:0] expv, input logic push);
    bit accepted = 0;
    in_valid  = 1'b1;
    in_state  = st;
    in_bypass = byp;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
    end
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end else if (push) begin
      exp_q.push_back(expv);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic latency(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int lat;
    logic [1:0] seen[4];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = 128'h0;
    in_bypass = 1'b0;
    out_ready = 1'b1;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  128'(in_ready),  128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy",      128'(busy),      128'(0));
    check("reset_out_state", out_state,       128'h0);
    check("reset_col_idx",   128'(col_idx),   128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 2. FIPS-197 round-1 vector, latency and column stepping
    send(C_V1_IN, 1'b0, C_V1_OUT, 1'b1);
    for (int i = 0; i < 4; i++) begin
      seen[i] = col_idx;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 4; i++) check("col_idx_step", 128'(seen[i]), 128'(i));
    check("busy_during_busy", 128'(busy), 128'(1));
    check("in_ready_during_busy", 128'(in_ready), 128'(0));
    lat = 3;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("normal_latency", 128'(lat), 128'(4));
    check("col_idx_in_done", 128'(col_idx), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_out", 128'(in_ready), 128'(1));

    // 3. Known columns
    send(C_V2_IN, 1'b0, C_V2_OUT, 1'b1);
    latency(lat);
    check("cols_latency", 128'(lat), 128'(4));
    check("cols_out_state", out_state, C_V2_OUT);
    repeat (2) @(posedge clk);
    #1;

    // 4. Bypass: DONE is entered on the accepting edge
    send(C_V1_IN, 1'b1, C_V1_IN, 1'b1);
    latency(lat);
    check("bypass_latency", 128'(lat), 128'(0));
    check("bypass_out_state", out_state, C_V1_IN);
    repeat (2) @(posedge clk);
    #1;

    // 5. Backpressure with a second block offered meanwhile
    out_ready = 1'b0;
    send(C_V1_IN, 1'b0, C_V1_OUT, 1'b1);
    latency(lat);
    check("bp_latency", 128'(lat), 128'(4));
    in_valid  = 1'b1;
    in_state  = C_V2_IN;
    in_bypass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_state", out_state, C_V1_OUT);
      check("bp_in_ready",  128'(in_ready),  128'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", 128'(in_ready), 128'(1));
    check("bp_release_valid", 128'(out_valid), 128'(0));
    send(C_V2_IN, 1'b0, C_V2_OUT, 1'b1);
    latency(lat);
    check("bp_second_latency", 128'(lat), 128'(4));
    repeat (2) @(posedge clk);
    #1;

    // 6. Reset mid-operation at col_idx == 2
    send(C_V1_IN, 1'b0, C_V1_OUT, 1'b0);
    lat = 0;
    while (col_idx != 2'd2 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("abort_reach_col2", 128'(col_idx), 128'(2));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy",      128'(busy),      128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_in_ready",  128'(in_ready),  128'(1));
    check("abort_col_idx",   128'(col_idx),   128'(0));
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_valid", 128'(out_valid), 128'(0));
    send(C_V2_IN, 1'b0, C_V2_OUT, 1'b1);
    latency(lat);
    check("post_abort_out_state", out_state, C_V2_OUT);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
